gol_mem_arbiter: RTL and testbench
==================================

GOL_MEM_ARBITER -- requirements
Module: gol_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, cell-RAM word address width.
REQ-002 Parameter DATA_W, 8, cell-RAM data width.
REQ-003 Parameter STARVE_LIMIT, 15, consecutive blocked cycles before an ENG or CPU request overrides VGA priority (range 1..255).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 vga_req  in  1  VGA scanout read request.
REQ-007 vga_addr  in  ADDR_W  VGA read address.
REQ-008 vga_gnt  out  1  VGA transfer accepted this cycle.
REQ-009 vga_rvalid / vga_rdata  out  1 / DATA_W  VGA read return.
REQ-010 eng_req, eng_we  in  1, 1  GOL update engine request and write enable.
REQ-011 eng_addr / eng_wdata  in  ADDR_W / DATA_W  engine address and write data.
REQ-012 eng_gnt, eng_rvalid / eng_rdata  out  1, 1 / DATA_W  engine accept and read return.
REQ-013 cpu_req, cpu_we, cpu_addr, cpu_wdata  in  1, 1, ADDR_W, DATA_W  Nios-side (board load/inspect) request.
REQ-014 cpu_gnt, cpu_rvalid / cpu_rdata  out  1, 1 / DATA_W  CPU accept and read return.
REQ-015 mem_addr / mem_we / mem_wdata  out  ADDR_W / 1 / DATA_W  single-port cell-RAM port, registered.
REQ-016 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr presented.
REQ-017 starve_evt  out  1  one-cycle pulse when a starvation override grant occurs.

Function
REQ-018 Transfer occurs in any cycle where X_req and X_gnt are both high; at most one X_gnt high per cycle.
REQ-019 X_gnt is combinational from X_req and registered arbiter state; X_gnt never high while X_req low.
REQ-020 Requester holds req/addr/we/wdata stable until transfer; back-to-back transfers from one requester every cycle are permitted.
REQ-021 Normal priority: VGA highest; between ENG and CPU, round-robin pointer rr (0=ENG next, 1=CPU next).
REQ-022 rr toggles only on an ENG or CPU transfer when both ENG and CPU requested that cycle; otherwise unchanged.
REQ-023 Per-requester 8-bit counters starve_eng, starve_cpu increment on each cycle X_req high and X_gnt low, saturate at 255, clear on X transfer or X_req low.
REQ-024 If a counter equals or exceeds STARVE_LIMIT, that requester is granted over VGA; if both starved, rr decides; starve_evt pulses in that cycle (combinational, registered output acceptable only if aligned to same cycle as grant).
REQ-025 Cycle T+1 after transfer in T: mem_addr/mem_we/mem_wdata carry the transfer; mem_we low in any cycle with no transfer in T.
REQ-026 Read transfer in T: X_rvalid high exactly in T+2 with X_rdata = mem_rdata of that cycle; write transfers produce no rvalid.
REQ-027 Return routing uses a 2-stage owner/read tag pipeline; rvalid for at most one requester per cycle, in transfer order.
REQ-028 X_rdata holds last returned value when X_rvalid low.
REQ-029 Writes and reads to same address in consecutive transfers are issued in transfer order; no forwarding.

Reset
REQ-030 While reset_n low at a rising edge: all gnt outputs low, all rvalid low, mem_we low, mem_addr/mem_wdata 0, rdata 0, rr 0, starve counters 0, tag pipeline cleared, starve_evt low.
REQ-031 Reset mid-operation drops in-flight reads: no rvalid is emitted for transfers made in the two cycles before reset.
REQ-032 First cycle after reset_n rises, arbitration operates normally.

Verification
REQ-033 Reset: hold reset_n low 3 cycles with all req high -> all gnt, rvalid, mem_we = 0; rr = 0.
REQ-034 Single reads: VGA read addr 0x0010, RAM holds 0xA5 -> vga_gnt in T, mem_addr=0x0010 in T+1, vga_rvalid=1 with 0xA5 in T+2.
REQ-035 Round-robin: ENG and CPU req continuously, VGA idle -> grants alternate ENG, CPU, ENG, CPU starting with ENG.
REQ-036 Starvation: VGA req every cycle, ENG write 0x3C to 0x0200 held -> VGA wins 15 cycles, ENG granted in 16th cycle with starve_evt=1, mem_we=1 next cycle; VGA resumes after.
REQ-037 Ordering: CPU write 0x77 to 0x0005 then VGA read 0x0005 next cycle -> vga_rdata=0x77; mem_we never high for VGA.
REQ-038 Reset mid-read: VGA read transfer at T, reset_n low at T+1 -> no vga_rvalid at T+2; all outputs at reset values.

Source files
------------

// File: rtl/gol_mem_arbiter.sv
// Three-way arbiter (VGA scanout, GOL engine, CPU) onto one single-port cell RAM.
// VGA has fixed priority unless ENG/CPU starve; read data returns two cycles after the grant.
module gol_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starve_evt
);

    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

    // Requester index: 0 = VGA, 1 = ENG, 2 = CPU
    logic [2:0]        req_vec;
    logic [2:0]        gnt_vec;
    logic [2:0]        starved_vec;
    logic [2:0]        rvalid_vec;
    logic [DATA_W-1:0] rdata_vec [3];

    logic              rr_reg, rr_next;
    logic              evt_next;
    logic              xfer;
    logic              sel_we;
    logic [1:0]        sel_owner;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              tag1_valid_reg, tag2_valid_reg;
    logic [1:0]        tag1_owner_reg, tag2_owner_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    assign req_vec        = {cpu_req, eng_req, vga_req};
    assign starved_vec[0] = 1'b0;

    // Per-requester starvation counters for ENG and CPU
    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_starve
            logic [7:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!reset_n || !req_vec[gi] || gnt_vec[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
            assign starved_vec[gi] = req_vec[gi] && (cnt_reg >= STARVE_LIM8);
        end
    endgenerate

    // Grant is combinational; everything is held off while reset is asserted
    always_comb begin
        gnt_vec  = '0;
        evt_next = 1'b0;
        if (reset_n) begin
            if (starved_vec[1] && starved_vec[2]) begin
                evt_next = 1'b1;
                if (rr_reg) gnt_vec[2] = 1'b1;
                else        gnt_vec[1] = 1'b1;
            end else if (starved_vec[1]) begin
                evt_next   = 1'b1;
                gnt_vec[1] = 1'b1;
            end else if (starved_vec[2]) begin
                evt_next   = 1'b1;
                gnt_vec[2] = 1'b1;
            end else if (vga_req) begin
                gnt_vec[0] = 1'b1;
            end else if (eng_req && cpu_req) begin
                if (rr_reg) gnt_vec[2] = 1'b1;
                else        gnt_vec[1] = 1'b1;
            end else if (eng_req) begin
                gnt_vec[1] = 1'b1;
            end else if (cpu_req) begin
                gnt_vec[2] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = vga_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_owner = 2'd0;
        if (gnt_vec[1]) begin
            sel_addr  = eng_addr;
            sel_we    = eng_we;
            sel_wdata = eng_wdata;
            sel_owner = 2'd1;
        end else if (gnt_vec[2]) begin
            sel_addr  = cpu_addr;
            sel_we    = cpu_we;
            sel_wdata = cpu_wdata;
            sel_owner = 2'd2;
        end
    end

    assign xfer = |gnt_vec;

    // Round-robin only advances when ENG and CPU actually contended
    always_comb begin
        rr_next = rr_reg;
        if ((gnt_vec[1] || gnt_vec[2]) && eng_req && cpu_req) begin
            rr_next = ~rr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_reg         <= 1'b0;
            tag1_valid_reg <= 1'b0;
            tag1_owner_reg <= 2'd0;
            tag2_valid_reg <= 1'b0;
            tag2_owner_reg <= 2'd0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_wdata_reg  <= '0;
        end else begin
            rr_reg         <= rr_next;
            tag1_valid_reg <= xfer && !sel_we;
            tag1_owner_reg <= sel_owner;
            tag2_valid_reg <= tag1_valid_reg;
            tag2_owner_reg <= tag1_owner_reg;
            mem_we_reg     <= xfer && sel_we;
            if (xfer) begin
                mem_addr_reg  <= sel_addr;
                mem_wdata_reg <= sel_wdata;
            end
        end
    end

    // Return routing: tag stage 2 lines up with RAM read data
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ret
            logic [DATA_W-1:0] hold_reg;
            assign rvalid_vec[gi] = reset_n && tag2_valid_reg && (tag2_owner_reg == 2'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : hold_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    hold_reg <= '0;
                end else if (rvalid_vec[gi]) begin
                    hold_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign vga_gnt    = gnt_vec[0];
    assign eng_gnt    = gnt_vec[1];
    assign cpu_gnt    = gnt_vec[2];
    assign vga_rvalid = rvalid_vec[0];
    assign eng_rvalid = rvalid_vec[1];
    assign cpu_rvalid = rvalid_vec[2];
    assign vga_rdata  = rdata_vec[0];
    assign eng_rdata  = rdata_vec[1];
    assign cpu_rdata  = rdata_vec[2];
    assign mem_addr   = mem_addr_reg;
    assign mem_we     = mem_we_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign starve_evt = evt_next;

endmodule

// File: tb/tb_gol_mem_arbiter.sv
// Directed bench for gol_mem_arbiter: cycle-accurate reference model checked every cycle,
// plus hand-computed expectations for reset, single read, round-robin, starvation and ordering.
module tb_gol_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LIMIT  = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vga_req, eng_req, eng_we, cpu_req, cpu_we;
    logic [ADDR_W-1:0] vga_addr, eng_addr, cpu_addr;
    logic [DATA_W-1:0] eng_wdata, cpu_wdata;
    logic              vga_gnt, vga_rvalid, eng_gnt, eng_rvalid, cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] vga_rdata, eng_rdata, cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              starve_evt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gol_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .starve_evt(starve_evt)
    );

    // Single-port RAM with one-cycle registered read
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: priority rules, contents of memory as seen in transfer order,
    // and a schedule of expected returns keyed by cycle number
    int          m_cnt_e = 0, m_cnt_c = 0;
    bit          m_rr = 1'b0;
    logic [7:0]  gold [0:65535];
    int          cyc = 0;
    int          ret_owner [int];
    logic [7:0]  ret_data [int];
    logic [7:0]  last_rd [3] = '{8'h00, 8'h00, 8'h00};
    bit          mx_valid = 1'b0, mx_we = 1'b0, mx_achk = 1'b0, mx_dchk = 1'b0;
    logic [15:0] mx_addr = '0;
    logic [7:0]  mx_wdata = '0;

    always @(negedge clk) begin : cmp
        int         win;
        bit         evt, se, sc, w, ev;
        logic [15:0] a;
        logic [7:0]  d, ed;
        logic [2:0]  rv_act;
        logic [7:0]  rd_act [3];

        if (mx_valid) begin
            chk("mem_we", mem_we, mx_we);
            if (mx_achk) chk("mem_addr", mem_addr, mx_addr);
            if (mx_dchk) chk("mem_wdata", mem_wdata, mx_wdata);
        end

        win = 0;
        evt = 1'b0;
        if (reset_n) begin
            se = eng_req && (m_cnt_e >= LIMIT);
            sc = cpu_req && (m_cnt_c >= LIMIT);
            if (se || sc) begin
                evt = 1'b1;
                if (se && sc) win = m_rr ? 3 : 2;
                else          win = se ? 2 : 3;
            end else if (vga_req)            win = 1;
            else if (eng_req && cpu_req)     win = m_rr ? 3 : 2;
            else if (eng_req)                win = 2;
            else if (cpu_req)                win = 3;
        end
        chk("vga_gnt", vga_gnt, win == 1);
        chk("eng_gnt", eng_gnt, win == 2);
        chk("cpu_gnt", cpu_gnt, win == 3);
        chk("starve_evt", starve_evt, evt);

        rv_act = {cpu_rvalid, eng_rvalid, vga_rvalid};
        rd_act[0] = vga_rdata;
        rd_act[1] = eng_rdata;
        rd_act[2] = cpu_rdata;
        for (int r = 0; r < 3; r++) begin
            ev = reset_n && ret_owner.exists(cyc) && (ret_owner[cyc] == r);
            ed = ev ? ret_data[cyc] : last_rd[r];
            chk($sformatf("rvalid%0d", r), rv_act[r], ev);
            chk($sformatf("rdata%0d", r), rd_act[r], ed);
            if (ev) last_rd[r] = ed;
        end
        if (ret_owner.exists(cyc)) begin
            ret_owner.delete(cyc);
            ret_data.delete(cyc);
        end

        mx_valid = 1'b1;
        if (!reset_n) begin
            m_cnt_e = 0;
            m_cnt_c = 0;
            m_rr    = 1'b0;
            ret_owner.delete();
            ret_data.delete();
            for (int r = 0; r < 3; r++) last_rd[r] = 8'h00;
            mx_we = 1'b0; mx_achk = 1'b1; mx_dchk = 1'b1; mx_addr = '0; mx_wdata = '0;
        end else begin
            mx_we = 1'b0; mx_achk = 1'b0; mx_dchk = 1'b0;
            if (win != 0) begin
                if (win == 1)      begin a = vga_addr; w = 1'b0;   d = 8'h00;     end
                else if (win == 2) begin a = eng_addr; w = eng_we; d = eng_wdata; end
                else               begin a = cpu_addr; w = cpu_we; d = cpu_wdata; end
                mx_achk = 1'b1; mx_addr = a; mx_we = w; mx_dchk = w; mx_wdata = d;
                if (w) gold[a] = d;
                else begin
                    ret_owner[cyc + 2] = win - 1;
                    ret_data[cyc + 2]  = gold[a];
                end
                if (win >= 2 && eng_req && cpu_req) m_rr = !m_rr;
            end
            m_cnt_e = (!eng_req || win == 2) ? 0 : ((m_cnt_e < 255) ? m_cnt_e + 1 : 255);
            m_cnt_c = (!cpu_req || win == 3) ? 0 : ((m_cnt_c < 255) ? m_cnt_c + 1 : 255);
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        vga_req = 1'b1; vga_addr = 16'h0010;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0010; eng_wdata = 8'h00;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h00;

        // Reset held with every requester asking
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_gnt", {vga_gnt, eng_gnt, cpu_gnt}, 3'b000);
            chk("rst_rvalid", {vga_rvalid, eng_rvalid, cpu_rvalid}, 3'b000);
            chk("rst_mem_we", mem_we, 1'b0);
            nxt();
        end
        reset_n = 1'b1;
        vga_req = 1'b0; eng_req = 1'b0; cpu_req = 1'b0;

        // Preload 0xA5 at 0x0010 through the CPU
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
        smp();
        chk("pre_cpu_gnt", cpu_gnt, 1'b1);
        nxt();
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Single VGA read: grant T, address T+1, data T+2
        vga_req = 1'b1; vga_addr = 16'h0010;
        smp();
        chk("rd_vga_gnt", vga_gnt, 1'b1);
        nxt();
        vga_req = 1'b0;
        smp();
        chk("rd_mem_addr", mem_addr, 16'h0010);
        chk("rd_mem_we", mem_we, 1'b0);
        nxt();
        smp();
        chk("rd_vga_rvalid", vga_rvalid, 1'b1);
        chk("rd_vga_rdata", vga_rdata, 8'hA5);
        nxt();

        // Round-robin between ENG and CPU, starting with ENG
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("rr_eng_gnt", eng_gnt, (i % 2) == 0);
            chk("rr_cpu_gnt", cpu_gnt, (i % 2) == 1);
            nxt();
        end
        eng_req = 1'b0; cpu_req = 1'b0;
        repeat (3) nxt();

        // ENG write starved by continuous VGA reads
        vga_req = 1'b1; vga_addr = 16'h0010;
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 16'h0200; eng_wdata = 8'h3C;
        for (int i = 0; i < 15; i++) begin
            smp();
            chk("stv_vga_gnt", vga_gnt, 1'b1);
            chk("stv_eng_wait", eng_gnt, 1'b0);
            nxt();
        end
        smp();
        chk("stv_eng_gnt", eng_gnt, 1'b1);
        chk("stv_evt", starve_evt, 1'b1);
        chk("stv_vga_blk", vga_gnt, 1'b0);
        nxt();
        eng_req = 1'b0; eng_we = 1'b0;
        smp();
        chk("stv_mem_we", mem_we, 1'b1);
        chk("stv_mem_addr", mem_addr, 16'h0200);
        chk("stv_mem_wdata", mem_wdata, 8'h3C);
        chk("stv_vga_resume", vga_gnt, 1'b1);
        nxt();
        vga_req = 1'b0;
        repeat (3) nxt();

        // ENG and CPU both starved: rr (back at 0) picks ENG, then CPU
        vga_req = 1'b1;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int i = 0; i < 15; i++) begin
            smp();
            chk("dstv_vga_gnt", vga_gnt, 1'b1);
            nxt();
        end
        smp();
        chk("dstv_eng_gnt", eng_gnt, 1'b1);
        chk("dstv_evt1", starve_evt, 1'b1);
        nxt();
        eng_req = 1'b0;
        smp();
        chk("dstv_cpu_gnt", cpu_gnt, 1'b1);
        chk("dstv_evt2", starve_evt, 1'b1);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("dstv_eng_rdata", eng_rdata, 8'h3C);
        chk("dstv_vga_back", vga_gnt, 1'b1);
        nxt();
        vga_req = 1'b0;
        repeat (3) nxt();

        // CPU write then VGA read of the same address: no forwarding, in order
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 8'h77;
        smp();
        chk("ord_cpu_gnt", cpu_gnt, 1'b1);
        nxt();
        cpu_req = 1'b0; cpu_we = 1'b0;
        vga_req = 1'b1; vga_addr = 16'h0005;
        smp();
        chk("ord_vga_gnt", vga_gnt, 1'b1);
        chk("ord_cpu_we", mem_we, 1'b1);
        nxt();
        vga_req = 1'b0;
        smp();
        chk("ord_vga_we", mem_we, 1'b0);
        chk("ord_vga_addr", mem_addr, 16'h0005);
        nxt();
        smp();
        chk("ord_vga_rvalid", vga_rvalid, 1'b1);
        chk("ord_vga_rdata", vga_rdata, 8'h77);
        nxt();

        // Reset one cycle after a VGA read transfer drops its return
        vga_req = 1'b1; vga_addr = 16'h0010;
        smp();
        chk("mr_vga_gnt", vga_gnt, 1'b1);
        nxt();
        vga_req = 1'b0;
        reset_n = 1'b0;
        smp();
        nxt();
        reset_n = 1'b1;
        smp();
        chk("mr_vga_rvalid", vga_rvalid, 1'b0);
        chk("mr_vga_rdata", vga_rdata, 8'h00);
        chk("mr_eng_rdata", eng_rdata, 8'h00);
        chk("mr_mem_we", mem_we, 1'b0);
        chk("mr_mem_addr", mem_addr, 16'h0000);
        chk("mr_mem_wdata", mem_wdata, 8'h00);
        nxt();

        // Arbitration normal straight after reset, rr back to ENG
        eng_req = 1'b1; eng_addr = 16'h0010;
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        smp();
        chk("post_rst_eng", eng_gnt, 1'b1);
        nxt();
        smp();
        chk("post_rst_cpu", cpu_gnt, 1'b1);
        nxt();
        eng_req = 1'b0; cpu_req = 1'b0;
        repeat (4) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
